pe_dot_sm5_packer: RTL and testbench

- Source side of the packed-operand interface of the 4x-packed dot-product multiplier.
- Takes a stream of two's-complement dot vectors, one per beat, and converts each element to SM_WIDTH-bit sign-magnitude with saturation.
- Groups consecutive vectors into NUM_PACKED slots and emits one packed word per group, in the operand layout the DSP-packed multiplier consumes on its feature or filter port.
- Sits between the feature/filter buffers and the PE dot array, with valid/ready flow control on both sides.

---
 rtl/pe_types.sv | 28 ++
 rtl/pe_fifo_2deep.sv | 60 ++++++
 rtl/pe_dot_sm5_packer.sv | 116 +++++++++++
 tb/tb_pe_dot_sm5_packer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_types.sv
// Shared PE datapath types: sign-magnitude element format and the
// saturating two's-complement to sign-magnitude conversion.
package pe_types;

    localparam int PE_IN_WIDTH = 8;
    localparam int PE_SM_WIDTH = 5;
    localparam logic [PE_SM_WIDTH-2:0] SM_MAGMAX = '1;

    typedef logic [PE_SM_WIDTH-1:0] sm_elem_t;

    typedef struct packed {
        logic                   sat;
        logic                   sign;
        logic [PE_SM_WIDTH-2:0] mag;
    } sm_conv_t;

    // |x| fits unsigned in PE_IN_WIDTH bits, including the most negative value.
    function automatic sm_conv_t to_sign_mag(input logic [PE_IN_WIDTH-1:0] x);
        sm_conv_t               r;
        logic [PE_IN_WIDTH-1:0] a;
        a      = x[PE_IN_WIDTH-1] ? (~x + 1'b1) : x;
        r.sat  = (a > PE_IN_WIDTH'(SM_MAGMAX));
        r.mag  = r.sat ? SM_MAGMAX : a[PE_SM_WIDTH-2:0];
        r.sign = x[PE_IN_WIDTH-1] && (r.mag != '0);
        return r;
    endfunction

endpackage

// File: rtl/pe_fifo_2deep.sv
// Two-entry valid/ready FIFO with a registered ready. The head register
// drives o_data directly, so data holds while stalled and after draining.
module pe_fifo_2deep #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [1:0]       r_count;
    logic             r_ready;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_push  = i_valid && r_ready;
    assign w_pop   = (r_count != 2'd0) && i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_head;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= 2'd0;
            r_ready <= 1'b0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt < 2'd2);
            if (w_pop && r_count == 2'd2)
                r_head <= r_tail;
            // A push lands in the head when the head is empty or is leaving this cycle.
            if (w_push) begin
                if (r_count == 2'd0 || (r_count == 2'd1 && w_pop))
                    r_head <= i_data;
                else
                    r_tail <= i_data;
            end
        end
    end

endmodule

// File: rtl/pe_dot_sm5_packer.sv
// Converts dot vectors to saturated sign-magnitude and packs NUM_PACKED
// consecutive vectors into one operand word for the DSP-packed multiplier.
module pe_dot_sm5_packer
    import pe_types::*;
#(
    parameter int DOT_SIZE   = 8,
    parameter int IN_WIDTH   = PE_IN_WIDTH,
    parameter int SM_WIDTH   = PE_SM_WIDTH,
    parameter int NUM_PACKED = 2
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic                                             i_valid,
    output logic                                             o_ready,
    input  logic [DOT_SIZE-1:0][IN_WIDTH-1:0]                i_data,
    input  logic                                             i_last,
    output logic                                             o_valid,
    input  logic                                             i_ready,
    output logic [NUM_PACKED-1:0][DOT_SIZE-1:0][SM_WIDTH-1:0] o_data,
    output logic [NUM_PACKED-1:0]                            o_slot_mask,
    input  logic                                             i_clear_stats,
    output logic [15:0]                                      o_sat_count
);

    localparam int SLOT_W = (NUM_PACKED > 1) ? $clog2(NUM_PACKED) : 1;
    localparam int CNT_W  = $clog2(DOT_SIZE + 1);
    localparam int FIFO_W = NUM_PACKED * DOT_SIZE * SM_WIDTH + NUM_PACKED;

    typedef logic [NUM_PACKED-1:0][DOT_SIZE-1:0][SM_WIDTH-1:0] word_t;

    logic [DOT_SIZE-1:0][SM_WIDTH-1:0] w_sm;
    logic [DOT_SIZE-1:0]               w_sat;
    logic [CNT_W-1:0]                  w_nsat;
    logic [16:0]                       w_sum;
    logic                              w_fifo_ready;
    logic                              w_accept;
    logic                              w_done;
    word_t                             w_word;
    logic [NUM_PACKED-1:0]             w_mask;
    logic [FIFO_W-1:0]                 w_fifo_out;

    word_t                 r_asm;
    logic [NUM_PACKED-1:0] r_mask;
    logic [SLOT_W-1:0]     r_slot;
    logic [15:0]           r_sat_count;

    for (genvar e = 0; e < DOT_SIZE; e++) begin : g_conv
        sm_conv_t w_c;
        assign w_c      = to_sign_mag(i_data[e]);
        assign w_sm[e]  = {w_c.sign, w_c.mag};
        assign w_sat[e] = w_c.sat;
    end

    always_comb begin
        w_nsat = '0;
        for (int e = 0; e < DOT_SIZE; e++)
            w_nsat = w_nsat + CNT_W'(w_sat[e]);
    end

    assign w_accept = i_valid && w_fifo_ready;
    assign w_done   = w_accept && ((r_slot == SLOT_W'(NUM_PACKED - 1)) || i_last);
    assign w_sum    = {1'b0, r_sat_count} + 17'(w_nsat);

    // Word as it stands once the current beat is merged in; pushed on completion.
    always_comb begin
        w_word         = r_asm;
        w_mask         = r_mask;
        w_word[r_slot] = w_sm;
        w_mask[r_slot] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_asm  <= '0;
            r_mask <= '0;
            r_slot <= '0;
        end else if (w_accept) begin
            if (w_done) begin
                r_asm  <= '0;
                r_mask <= '0;
                r_slot <= '0;
            end else begin
                r_asm  <= w_word;
                r_mask <= w_mask;
                r_slot <= r_slot + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_sat_count <= '0;
        else if (i_clear_stats)
            r_sat_count <= '0;
        else if (w_accept)
            r_sat_count <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
    end

    pe_fifo_2deep #(
        .WIDTH(FIFO_W)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .i_valid(w_done),
        .o_ready(w_fifo_ready),
        .i_data ({w_word, w_mask}),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (w_fifo_out)
    );

    assign {o_data, o_slot_mask} = w_fifo_out;
    assign o_ready               = w_fifo_ready;
    assign o_sat_count           = r_sat_count;

endmodule

// File: tb/tb_pe_dot_sm5_packer.sv
// Bench for pe_dot_sm5_packer: directed scenarios with literal expectations
// plus a per-cycle compare against a queue-based behavioural model.
module tb_pe_dot_sm5_packer;

    localparam int DS = 8;
    localparam int IW = 8;
    localparam int SW = 5;
    localparam int NP = 2;

    typedef logic [NP*DS*SW-1:0] wdata_t;
    typedef logic [DS-1:0][IW-1:0] vec_t;

    logic clock = 1'b0;
    logic reset;
    logic i_valid, i_last, i_ready, i_clear_stats;
    vec_t i_data;
    logic o_ready, o_valid;
    logic [NP-1:0][DS-1:0][SW-1:0] o_data;
    logic [NP-1:0] o_slot_mask;
    logic [15:0] o_sat_count;

    pe_dot_sm5_packer #(.DOT_SIZE(DS), .IN_WIDTH(IW), .SM_WIDTH(SW), .NUM_PACKED(NP)) dut (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_slot_mask(o_slot_mask),
        .i_clear_stats(i_clear_stats), .o_sat_count(o_sat_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errs = 0;
    int ncmp = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        ncmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference conversion from the arithmetic definition.
    function automatic logic [SW-1:0] m_sm(input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (m > 15) m = 15;
        return {(v < 0 && m != 0), 4'(m)};
    endfunction

    function automatic bit m_clip(input int v);
        return ((v < 0) ? -v : v) > 15;
    endfunction

    // Model state describes the DUT after the most recent rising edge.
    wdata_t     mq_d[$];
    logic [1:0] mq_m[$];
    wdata_t     part_d;
    logic [1:0] part_m;
    int         part_n;
    int         m_cnt;
    bit         m_rdy;

    always @(negedge clock) begin
        bit acc, pop;
        int v, nsat;
        if (reset) begin
            mq_d.delete(); mq_m.delete();
            part_d = '0; part_m = '0; part_n = 0; m_cnt = 0; m_rdy = 0;
            chk("rst_valid", 80'(o_valid), 80'(0));
            chk("rst_ready", 80'(o_ready), 80'(0));
            chk("rst_sat", 80'(o_sat_count), 80'(0));
        end else begin
            chk("ready", 80'(o_ready), 80'(m_rdy));
            chk("valid", 80'(o_valid), 80'(mq_d.size() != 0));
            if (mq_d.size() != 0) begin
                chk("data", 80'(o_data), 80'(mq_d[0]));
                chk("mask", 80'(o_slot_mask), 80'(mq_m[0]));
            end
            chk("sat_count", 80'(o_sat_count), 80'(m_cnt));
            pop = (mq_d.size() != 0) && i_ready;
            acc = i_valid && m_rdy;
            if (pop) begin
                void'(mq_d.pop_front());
                void'(mq_m.pop_front());
            end
            nsat = 0;
            if (acc) begin
                vectors++;
                for (int e = 0; e < DS; e++) begin
                    v = int'($signed(i_data[e]));
                    part_d[(part_n*DS+e)*SW +: SW] = m_sm(v);
                    if (m_clip(v)) nsat++;
                end
                part_m[part_n] = 1'b1;
                part_n++;
                if (part_n == NP || i_last) begin
                    mq_d.push_back(part_d);
                    mq_m.push_back(part_m);
                    part_d = '0; part_m = '0; part_n = 0;
                end
            end
            if (i_clear_stats) m_cnt = 0;
            else if (acc) m_cnt = (m_cnt + nsat > 65535) ? 65535 : m_cnt + nsat;
            m_rdy = (mq_d.size() < 2);
        end
    end

    task automatic send(input vec_t d, input logic l, input logic c);
        int n;
        bit done;
        n = 0; done = 0;
        @(posedge clock); #1;
        i_valid = 1; i_data = d; i_last = l; i_clear_stats = c;
        while (!done) begin
            @(negedge clock);
            if (o_ready) done = 1;
            else begin
                n++;
                if (n > 50) begin
                    chk("send_timeout", 80'(0), 80'(1));
                    done = 1;
                end else begin
                    @(posedge clock); #1;
                end
            end
        end
        @(posedge clock); #1;
        i_valid = 0; i_last = 0; i_clear_stats = 0;
    endtask

    function automatic logic [IW-1:0] rnd_el();
        case ($urandom_range(0, 4))
            0:       return 8'h80;
            1:       return 8'($urandom_range(0, 33)) - 8'd17;
            2:       return 8'h00;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        vec_t   d;
        wdata_t exp, hold;
        int     nacc;
        reset = 1; i_valid = 0; i_last = 0; i_ready = 1; i_clear_stats = 0; i_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_data", 80'(o_data), 80'(0));
        chk("rst_mask", 80'(o_slot_mask), 80'(0));
        @(posedge clock); #1 reset = 0;
        @(negedge clock);
        @(negedge clock);
        chk("ready_after_rst", 80'(o_ready), 80'(1));

        // Basic pairing: {3,-3,...} twice
        for (int e = 0; e < DS; e++) d[e] = (e % 2 == 0) ? 8'd3 : 8'hFD;
        send(d, 0, 0);
        send(d, 0, 0);
        @(negedge clock);
        exp = {2{{4{5'b10011, 5'b00011}}}};
        chk("pair_valid", 80'(o_valid), 80'(1));
        chk("pair_data", 80'(o_data), 80'(exp));
        chk("pair_mask", 80'(o_slot_mask), 80'(2'b11));

        // Saturation and zero, closed early with i_last
        d = {8'h00, 8'h00, 8'hF1, 8'h0F, 8'hF0, 8'h10, 8'h7F, 8'h80};
        send(d, 1, 0);
        @(negedge clock);
        exp = {40'h0, 5'h00, 5'h00, 5'h1F, 5'h0F, 5'h1F, 5'h0F, 5'h0F, 5'h1F};
        chk("sat_data", 80'(o_data), 80'(exp));
        chk("early_mask", 80'(o_slot_mask), 80'(2'b01));
        chk("sat_plus4", 80'(o_sat_count), 80'(4));

        // Clear coincident with a clipped beat; that beat must land in slot 0
        d = {DS{8'h80}};
        send(d, 0, 1);
        @(negedge clock);
        chk("clear_wins", 80'(o_sat_count), 80'(0));
        d = '0;
        send(d, 0, 0);
        @(negedge clock);
        exp = {40'h0, {8{5'h1F}}};
        chk("after_early_data", 80'(o_data), 80'(exp));
        chk("after_early_mask", 80'(o_slot_mask), 80'(2'b11));

        // Backpressure
        repeat (3) @(negedge clock);
        @(posedge clock); #1;
        i_ready = 0; nacc = 0;
        for (int k = 0; k < 10; k++) begin
            i_valid = 1;
            if (k == 0 || nacc > 0) for (int e = 0; e < DS; e++) i_data[e] = rnd_el();
            @(negedge clock);
            if (o_ready) nacc++;
            @(posedge clock); #1;
        end
        i_valid = 0;
        @(negedge clock);
        chk("bp_accepted", 80'(nacc), 80'(4));
        chk("bp_ready_low", 80'(o_ready), 80'(0));
        chk("bp_valid", 80'(o_valid), 80'(1));
        hold = o_data;
        repeat (3) @(negedge clock);
        chk("bp_stable", 80'(o_data), 80'(hold));
        @(posedge clock); #1 i_ready = 1;
        @(negedge clock);
        @(negedge clock);
        chk("bp_ready_back", 80'(o_ready), 80'(1));
        repeat (3) @(negedge clock);

        // Reset mid-group
        d = {DS{8'h7F}};
        send(d, 0, 0);
        @(posedge clock); #1 reset = 1;
        @(negedge clock);
        chk("midrst_valid", 80'(o_valid), 80'(0));
        chk("midrst_sat", 80'(o_sat_count), 80'(0));
        @(posedge clock); #1 reset = 0;
        send({DS{8'd5}}, 0, 0);
        send({DS{8'hF9}}, 0, 0);
        @(negedge clock);
        exp = {{8{5'b10111}}, {8{5'b00101}}};
        chk("midrst_data", 80'(o_data), 80'(exp));
        chk("midrst_mask", 80'(o_slot_mask), 80'(2'b11));

        // Counter sticks at 0xFFFF
        @(posedge clock); #1;
        i_ready = 1; i_valid = 1; i_data = {DS{8'h80}};
        repeat (8200) @(posedge clock);
        #1 i_valid = 0;
        @(negedge clock);
        chk("sat_sticky", 80'(o_sat_count), 80'(16'hFFFF));

        // Random soak
        for (int c = 0; c < 12000; c++) begin
            @(posedge clock); #1;
            i_valid = ($urandom_range(0, 9) < 7);
            i_ready = ($urandom_range(0, 9) < 6);
            i_last = ($urandom_range(0, 4) == 0);
            i_clear_stats = ($urandom_range(0, 63) == 0);
            for (int e = 0; e < DS; e++) i_data[e] = rnd_el();
        end
        @(posedge clock); #1;
        i_valid = 0; i_last = 0; i_clear_stats = 0; i_ready = 1;
        repeat (6) @(negedge clock);
        chk("drained", 80'(o_valid), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
